// File: rtl/io_router_pkg.sv
// io_router_pkg: register offsets and status bit positions shared by the I/O router
package io_router_pkg;
  localparam int NREGS = 6;
  localparam logic [2:0] REG_DATA  = 3'd0;
  localparam logic [2:0] REG_PTR   = 3'd1;
  localparam logic [2:0] REG_SPID  = 3'd2;
  localparam logic [2:0] REG_STAT  = 3'd3;
  localparam logic [2:0] REG_CURS  = 3'd4;
  localparam logic [2:0] REG_KBCTL = 3'd5;
  localparam int ST_NONEMPTY = 0;
  localparam int ST_OVF      = 1;
  localparam int ST_TIMEOUT  = 6;
  localparam int ST_BUSY     = 7;
endpackage

// File: rtl/io_router_if.sv
// io_router_if: core data-bus signals between the AVR core and the I/O router
interface io_router_if;
  logic [15:0] address;
  logic [7:0]  cpu_out;
  logic        we;
  logic        read;
  logic [7:0]  mem_in;
  logic [7:0]  din;
  modport master (output address, cpu_out, we, read, mem_in, input din);
  modport slave  (input address, cpu_out, we, read, mem_in, output din);
endinterface

// File: rtl/io_router_kb_fifo.sv
// kb_fifo: byte-wide synchronous FIFO; the caller only pushes when space is available
module kb_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd];
  // read/write pointers and occupancy; flush empties the FIFO outright
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage needs no reset: it is only read through valid pointers
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= wdata;
endmodule

// File: rtl/io_router.sv
// io_router: memory-mapped I/O window for keyboard FIFO, font RAM, SPI and text cursor
module io_router
  import io_router_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0020,
  parameter int KB_DEPTH = 8,
  parameter int FONT_AW  = 12,
  parameter int CURSOR_W = 11
) (
  input  logic                clock,
  input  logic                reset_n,
  io_router_if.slave          bus,
  input  logic                kb_hit,
  input  logic [7:0]          kb_data,
  output logic                intr,
  output logic [FONT_AW-1:0]  font_addr,
  output logic [7:0]          font_wdata,
  output logic                font_we,
  input  logic [7:0]          font_rdata,
  output logic [7:0]          spi_out,
  output logic [1:0]          spi_cmd,
  output logic                spi_sent,
  input  logic [7:0]          spi_din,
  input  logic [1:0]          spi_st,
  output logic [CURSOR_W-1:0] cursor
);
  localparam int KAW = $clog2(KB_DEPTH);
  logic [15:0]        offset;
  logic [2:0]         off;
  logic               in_win, wr_hit, push, pop, flush, full, empty, kb_ovf;
  logic [7:0]         head, status, rdata;
  logic [KAW:0]       count;
  logic [FONT_AW-1:0] ptr, wr_addr;
  assign offset    = bus.address - BASE;
  assign in_win    = offset < 16'(NREGS);
  assign off       = offset[2:0];
  assign wr_hit    = bus.we && in_win;
  assign pop       = bus.read && bus.address == BASE && !empty;
  assign flush     = wr_hit && off == REG_KBCTL && bus.cpu_out[0];
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign push      = kb_hit && (!full || pop) && !flush;
  assign font_addr = font_we ? wr_addr : ptr;
  assign bus.din   = rdata;
  kb_fifo #(.DEPTH(KB_DEPTH)) u_fifo (
    .clk(clock), .rst_n(reset_n), .push(push), .pop(pop), .flush(flush),
    .wdata(kb_data), .head(head), .full(full), .empty(empty), .count(count)
  );
  // read mux: window registers, otherwise RAM data
  always_comb begin
    status = '0;
    status[ST_BUSY]     = spi_st[0];
    status[ST_TIMEOUT]  = spi_st[1];
    status[ST_OVF]      = kb_ovf;
    status[ST_NONEMPTY] = !empty;
    rdata = bus.mem_in;
    if (in_win)
      case (off)
        REG_DATA: rdata = empty ? 8'h00 : head;
        REG_PTR:  rdata = font_rdata;
        REG_SPID: rdata = spi_din;
        REG_STAT: rdata = status;
        REG_CURS: rdata = cursor[7:0];
        default:  rdata = 8'(count);
      endcase
  end
  // register writes, font port, SPI strobe, keyboard interrupt and overflow flag
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      intr       <= 1'b0;
      kb_ovf     <= 1'b0;
      font_we    <= 1'b0;
      font_wdata <= '0;
      wr_addr    <= '0;
      ptr        <= '0;
      spi_out    <= '0;
      spi_cmd    <= '0;
      spi_sent   <= 1'b0;
      cursor     <= '0;
    end else begin
      font_we  <= wr_hit && off == REG_DATA;
      spi_sent <= wr_hit && off == REG_STAT;
      if (push) intr <= ~intr;
      if (flush) kb_ovf <= 1'b0;
      else if (kb_hit && full && !pop) kb_ovf <= 1'b1;
      if (wr_hit && off == REG_DATA) begin
        wr_addr    <= ptr;
        font_wdata <= bus.cpu_out;
        ptr        <= ptr + 1'b1;
      end else if (wr_hit && off == REG_PTR) ptr <= {ptr[FONT_AW-9:0], bus.cpu_out};
      if (wr_hit && off == REG_SPID) spi_out <= bus.cpu_out;
      if (wr_hit && off == REG_STAT) spi_cmd <= bus.cpu_out[1:0];
      if (wr_hit && off == REG_CURS) cursor <= {cursor[CURSOR_W-9:0], bus.cpu_out};
    end
endmodule

// File: doc/io_router.md
# io_router

Parametrised memory-mapped I/O port controller between the AVR core data bus and the board peripherals (PS/2 keyboard, font RAM, SD-card SPI, text cursor). It decodes a 6-register window at a configurable base address and muxes read data back to the core. It adds four things to the fixed-address, single-byte design: a keyboard FIFO with overflow flag, read-back through the font pointer, a status register, and configurable widths.

## Interface
- BASE, 16'h0020: address of register 0; window is BASE..BASE+5.
- KB_DEPTH, 8: keyboard FIFO entries; power of two, 2..256.
- FONT_AW, 12: font RAM address width, 9..16.
- CURSOR_W, 11: cursor register width, 9..16.

- clock  in  1  system clock (25 MHz core clock).
- reset_n  in  1  asynchronous, active-low reset.
- address  in  16  core data address.
- cpu_out  in  8  core write data.
- we  in  1  core write strobe, one cycle.
- read  in  1  core read-complete strobe, one cycle.
- mem_in  in  8  RAM read data for addresses outside the window.
- din  out  8  combinational read data to the core.
- kb_hit  in  1  PS/2 byte-valid pulse.
- kb_data  in  8  PS/2 byte.
- intr  out  1  interrupt toggle; each toggle is one event.
- font_addr  out  FONT_AW  font RAM port address.
- font_wdata  out  8  font RAM write data.
- font_we  out  1  font RAM write pulse.
- font_rdata  in  8  font RAM read data, one-cycle synchronous latency.
- spi_out  out  8  SPI transmit byte.
- spi_cmd  out  2  SPI command.
- spi_sent  out  1  one-cycle SPI command strobe.
- spi_din  in  8  SPI received byte.
- spi_st  in  2  bit0 busy, bit1 timeout.
- cursor  out  CURSOR_W  text cursor position.

## Operation
- Register map (offset from BASE):
  - +0: R is FIFO head, popped on `read`. W writes font data at ptr, then ptr+1.
  - +1: R is font_rdata. W shifts the pointer: ptr <= {ptr[FONT_AW-9:0], cpu_out}.
  - +2: R is spi_din. W latches spi_out.
  - +3: R is status {spi_st[0], spi_st[1], 4'b0, kb_ovf, kb_nonempty}. W sets spi_cmd <= cpu_out[1:0] and pulses spi_sent.
  - +4: R is cursor[7:0]. W shifts the cursor: cursor <= {cursor[CURSOR_W-9:0], cpu_out}.
  - +5: R is the FIFO count, zero-extended to 8 bits. W with bit0=1 flushes the FIFO and clears kb_ovf.
- din: register value when address is inside the window, otherwise mem_in.
- Keyboard push on kb_hit:
  - FIFO not full: store the byte and toggle intr.
  - FIFO full: drop the byte, set kb_ovf (sticky), leave intr unchanged.
- Pop: `read` with address==BASE while the FIFO is non-empty. Reading an empty FIFO returns 8'h00 and does not pop.
- Push and pop in the same cycle: both take effect, count unchanged. When the FIFO is full, this push is accepted and no overflow is flagged.
- Flush in the same cycle as a push: flush wins, the byte is discarded, intr does not toggle.
- ptr wraps modulo 2^FONT_AW. The cursor shift discards its upper bits.
- font_addr = wr_addr while font_we is high, otherwise ptr.

## Timing
- Reset values: intr 0, font_we 0, spi_sent 0, spi_cmd 0, spi_out 0, cursor 0, ptr 0, font_addr 0, font_wdata 0, FIFO empty, kb_ovf 0. din follows its inputs.
- Font write: the cycle after `we` at +0, font_we=1 for one cycle with wr_addr = old ptr. ptr has already incremented in that cycle.
- Font read at +1 is valid once ptr has been stable for one cycle. Software sets ptr, then reads.
- spi_sent is high exactly the cycle after the write to +3. spi_cmd is valid in the same cycle.
- intr toggles the cycle after an accepted kb_hit.
- FIFO count updates one cycle after a push or pop. The +0 head read is combinational from FIFO storage.
- Reset asserted mid-operation clears all state immediately. In-flight strobes are cancelled.

## Structure
- Package io_router_pkg holds:
  - register offset constants: REG_DATA, REG_PTR, REG_SPID, REG_STAT, REG_CURS, REG_KBCTL;
  - status bit positions.
- Sub-module kb_fifo: a synchronous FIFO parametrised by depth and width 8, with push, pop, flush, full, empty and count.
- Address decode, font port, SPI and cursor logic stay in io_router.

## Test plan
- Write 8'h0A then 8'hBC to +1, then 8'h55 to +0 → font_we pulse with font_addr=12'hABC and font_wdata=8'h55; ptr reads back as 12'hABD.
- Push 3 bytes 11/22/33 → intr toggles 3 times, +5 reads 3; three reads of +0 return 11, 22, 33; a fourth read returns 00 and count stays 0.
- Push 9 bytes with KB_DEPTH=8 → status bit1 (kb_ovf)=1, count 8, ninth byte lost; writing 1 to +5 gives count 0 and kb_ovf 0.
- FIFO full, kb_hit and a pop of +0 in the same cycle → count stays 8, kb_ovf stays 0, new byte is at the tail.
- Write 8'h02 to +3 → spi_cmd=2'b10 and a single-cycle spi_sent; with spi_st=2'b01, a read of +3 returns 8'h80.
- Set ptr to 12'hFFF, write +0 twice, then assert reset_n low between the writes → first write goes to FFF; after reset, ptr, cursor and FIFO are zero and no font_we is emitted.
